// File: rtl/systolic_drain.sv
// Snapshots the PE accumulator grid when the controller reports done, then streams it out row-major.
// One cycle from done to the first valid word, one word per cycle while recv_rdy is high, recv_val held until accepted.
module systolic_drain #(
    parameter int size     = 16,
    parameter int BITWIDTH = 32,
    localparam int N  = size * size,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     done,
    input  logic [N*BITWIDTH-1:0]    results,
    output logic                     acc_clr,
    output logic [BITWIDTH-1:0]      recv_msg,
    output logic                     recv_val,
    input  logic                     recv_rdy,
    output logic [IW-1:0]            idx,
    output logic                     busy,
    output logic                     drained
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [IW-1:0] LAST = IW'(N - 1);

    state_t              state_q;
    logic [IW-1:0]       idx_q;
    logic                recv_val_q;
    logic                busy_q;
    logic                acc_clr_q;
    logic                drained_q;
    logic [BITWIDTH-1:0] snap_q [N];

    // Snapshot only on the IDLE->SEND edge so later changes on results cannot leak into the stream.
    always_ff @(posedge clk) begin
        if (!rst && state_q == IDLE && done) begin
            for (int i = 0; i < N; i++) begin
                snap_q[i] <= results[i*BITWIDTH +: BITWIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            recv_val_q <= 1'b0;
            busy_q     <= 1'b0;
            acc_clr_q  <= 1'b0;
            drained_q  <= 1'b0;
        end else begin
            acc_clr_q <= 1'b0;
            drained_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (done) begin
                        state_q    <= SEND;
                        idx_q      <= '0;
                        recv_val_q <= 1'b1;
                        busy_q     <= 1'b1;
                        acc_clr_q  <= 1'b1;
                    end
                end
                SEND: begin
                    if (recv_rdy) begin
                        if (idx_q == LAST) begin
                            state_q    <= HOLD;
                            idx_q      <= '0;
                            recv_val_q <= 1'b0;
                            busy_q     <= 1'b0;
                            drained_q  <= 1'b1;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    // Wait for done to fall so one result set is emitted only once.
                    if (!done) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    idx_q      <= '0;
                    recv_val_q <= 1'b0;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

    assign recv_val = recv_val_q;
    assign recv_msg = recv_val_q ? snap_q[idx_q] : '0;
    assign idx      = idx_q;
    assign busy     = busy_q;
    assign acc_clr  = acc_clr_q;
    assign drained  = drained_q;

endmodule

// File: tb/tb_systolic_drain.sv
// Directed bench for systolic_drain: a 2x2/8-bit instance driven from a vector table plus corner sequences,
// and a 16x16/32-bit instance streamed end to end.
module tb_systolic_drain;

    logic clk;
    int   errors;
    int   checks;

    // 2x2, 8-bit instance
    logic        rst_a, done_a, rdy_a;
    logic [31:0] results_a;
    logic        acc_a, val_a, busy_a, drn_a;
    logic [7:0]  msg_a;
    logic [1:0]  idx_a;

    // 16x16, 32-bit instance
    logic          rst_b, done_b, rdy_b;
    logic [8191:0] results_b;
    logic          acc_b, val_b, busy_b, drn_b;
    logic [31:0]   msg_b;
    logic [7:0]    idx_b;

    systolic_drain #(.size(2), .BITWIDTH(8)) u_a (
        .clk(clk), .rst(rst_a), .done(done_a), .results(results_a),
        .acc_clr(acc_a), .recv_msg(msg_a), .recv_val(val_a), .recv_rdy(rdy_a),
        .idx(idx_a), .busy(busy_a), .drained(drn_a)
    );

    systolic_drain #(.size(16), .BITWIDTH(32)) u_b (
        .clk(clk), .rst(rst_b), .done(done_b), .results(results_b),
        .acc_clr(acc_b), .recv_msg(msg_b), .recv_val(val_b), .recv_rdy(rdy_b),
        .idx(idx_b), .busy(busy_b), .drained(drn_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic       rst;
        logic       done;
        logic       rdy;
        logic       ff;
        logic       val;
        logic [7:0] msg;
        logic [1:0] idx;
        logic       busy;
        logic       acc;
        logic       drn;
    } vec_t;

    localparam logic [31:0] BASE_A = 32'h44332211;
    localparam logic [31:0] NEW_A  = 32'h88776655;

    vec_t tbl [18];

    function automatic vec_t mk(input logic rst, input logic done, input logic rdy, input logic ff,
                                input logic val, input logic [7:0] msg, input logic [1:0] idx,
                                input logic busy, input logic acc, input logic drn);
        vec_t v;
        v.rst = rst; v.done = done; v.rdy = rdy; v.ff = ff;
        v.val = val; v.msg = msg; v.idx = idx; v.busy = busy; v.acc = acc; v.drn = drn;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_a(input string tag, input logic val, input logic [7:0] msg, input logic [1:0] idx,
                         input logic busy, input logic acc, input logic drn);
        chk({tag, ".val"},  32'(val_a),  32'(val));
        chk({tag, ".msg"},  32'(msg_a),  32'(msg));
        chk({tag, ".idx"},  32'(idx_a),  32'(idx));
        chk({tag, ".busy"}, 32'(busy_a), 32'(busy));
        chk({tag, ".acc"},  32'(acc_a),  32'(acc));
        chk({tag, ".drn"},  32'(drn_a),  32'(drn));
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst_a = 1'b1; done_a = 1'b0; rdy_a = 1'b0; results_a = BASE_A;
        rst_b = 1'b1; done_b = 1'b0; rdy_b = 1'b0;
        for (int i = 0; i < 256; i++) results_b[i*32 +: 32] = 32'(i);

        //               rst  done rdy  ff   val  msg    idx  busy acc  drn
        tbl[0]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0);
        tbl[1]  = mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h11, 2'd0, 1'b1, 1'b1, 1'b0);
        tbl[2]  = mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h22, 2'd1, 1'b1, 1'b0, 1'b0);
        tbl[3]  = mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h33, 2'd2, 1'b1, 1'b0, 1'b0);
        tbl[4]  = mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h44, 2'd3, 1'b1, 1'b0, 1'b0);
        tbl[5]  = mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0, 1'b1);
        tbl[6]  = mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0);
        tbl[7]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h11, 2'd0, 1'b1, 1'b1, 1'b0);
        tbl[8]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h11, 2'd0, 1'b1, 1'b0, 1'b0);
        tbl[9]  = mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h22, 2'd1, 1'b1, 1'b0, 1'b0);
        tbl[10] = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h22, 2'd1, 1'b1, 1'b0, 1'b0);
        tbl[11] = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h22, 2'd1, 1'b1, 1'b0, 1'b0);
        tbl[12] = mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h33, 2'd2, 1'b1, 1'b0, 1'b0);
        tbl[13] = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h33, 2'd2, 1'b1, 1'b0, 1'b0);
        tbl[14] = mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h44, 2'd3, 1'b1, 1'b0, 1'b0);
        tbl[15] = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h44, 2'd3, 1'b1, 1'b0, 1'b0);
        tbl[16] = mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0, 1'b1);
        tbl[17] = mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 18; i++) begin
            rst_a     = tbl[i].rst;
            done_a    = tbl[i].done;
            rdy_a     = tbl[i].rdy;
            results_a = tbl[i].ff ? 32'hFFFFFFFF : BASE_A;
            step();
            chk_a($sformatf("row%0d", i), tbl[i].val, tbl[i].msg, tbl[i].idx,
                  tbl[i].busy, tbl[i].acc, tbl[i].drn);
        end

        // done held high after a drain: HOLD must not re-emit, even with new results present
        results_a = NEW_A;
        for (int k = 0; k < 20; k++) begin
            done_a = 1'b1;
            step();
            chk($sformatf("hold%0d.val", k), 32'(val_a), 32'd0);
            chk($sformatf("hold%0d.drn", k), 32'(drn_a), 32'd0);
        end
        done_a = 1'b0;
        step();
        chk_a("idle", 1'b0, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0);
        done_a = 1'b1;
        rdy_a  = 1'b1;
        step();
        chk_a("new0", 1'b1, 8'h55, 2'd0, 1'b1, 1'b1, 1'b0);
        for (int k = 1; k < 4; k++) begin
            step();
            chk_a($sformatf("new%0d", k), 1'b1, 8'(8'h55 + 8'h11 * k), 2'(k), 1'b1, 1'b0, 1'b0);
        end
        step();
        chk_a("new_end", 1'b0, 8'h00, 2'd0, 1'b0, 1'b0, 1'b1);

        // reset after two transfers abandons the stream; done still high restarts it
        done_a = 1'b0;
        step();
        results_a = BASE_A;
        done_a    = 1'b1;
        step();
        chk_a("pre0", 1'b1, 8'h11, 2'd0, 1'b1, 1'b1, 1'b0);
        step();
        step();
        chk_a("pre2", 1'b1, 8'h33, 2'd2, 1'b1, 1'b0, 1'b0);
        rst_a = 1'b1;
        step();
        chk_a("rst", 1'b0, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0);
        rst_a = 1'b0;
        step();
        chk_a("re0", 1'b1, 8'h11, 2'd0, 1'b1, 1'b1, 1'b0);
        for (int k = 1; k < 4; k++) begin
            step();
            chk_a($sformatf("re%0d", k), 1'b1, 8'(8'h11 * (k + 1)), 2'(k), 1'b1, 1'b0, 1'b0);
        end
        step();
        chk_a("re_end", 1'b0, 8'h00, 2'd0, 1'b0, 1'b0, 1'b1);

        // full-size array: word i equals i, one word per cycle
        rst_a  = 1'b1;
        rst_b  = 1'b1;
        step();
        chk("b.rst.val", 32'(val_b), 32'd0);
        chk("b.rst.idx", 32'(idx_b), 32'd0);
        rst_b  = 1'b0;
        done_b = 1'b1;
        rdy_b  = 1'b1;
        for (int k = 1; k <= 256; k++) begin
            step();
            chk($sformatf("b%0d.val", k), 32'(val_b), 32'd1);
            chk($sformatf("b%0d.idx", k), 32'(idx_b), 32'(k - 1));
            chk($sformatf("b%0d.msg", k), msg_b, 32'(k - 1));
            chk($sformatf("b%0d.acc", k), 32'(acc_b), (k == 1) ? 32'd1 : 32'd0);
            chk($sformatf("b%0d.drn", k), 32'(drn_b), 32'd0);
        end
        step();
        chk("b_end.val", 32'(val_b), 32'd0);
        chk("b_end.drn", 32'(drn_b), 32'd1);
        chk("b_end.acc", 32'(acc_b), 32'd0);
        step();
        chk("b_after.drn", 32'(drn_b), 32'd0);
        chk("b_after.val", 32'(val_b), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
